regfile_wb: RTL
===============

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter RSP_RESET, default 64'h0, reset value of %rsp (register 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port icode  input  4  instruction code of the instruction in writeback.
REQ-005 SHALL have port cnd  input  1  condition result from execute; gates cmovxx writes.
REQ-006 SHALL have port stat  input  3  instruction status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-007 SHALL have port dstE  input  4  destination for valE; 4'hF = none.
REQ-008 SHALL have port dstM  input  4  destination for valM; 4'hF = none.
REQ-009 SHALL have port valE  input  64  ALU result to write.
REQ-010 SHALL have port valM  input  64  memory read data to write.
REQ-011 SHALL have port srcA  input  4  read-port A select; 4'hF = none.
REQ-012 SHALL have port srcB  input  4  read-port B select; 4'hF = none.
REQ-013 SHALL have port valA  output  64  register[srcA].
REQ-014 SHALL have port valB  output  64  register[srcB].
REQ-015 SHALL have port halted  output  1  sticky: a non-AOK stat has reached writeback.

Function
REQ-016 SHALL hold 15 64-bit registers, indices 0..14; index 15 is not storage.
REQ-017 SHALL drive valA/valB combinationally from current register contents; select 4'hF SHALL yield 64'h0.
REQ-018 SHALL read pre-edge contents: a write at edge N is visible on valA/valB only after edge N.
REQ-019 SHALL write valE to register[dstE] at the rising edge when dstE != 4'hF and write enable is active.
REQ-020 SHALL write valM to register[dstM] at the same edge under the same conditions, both ports in one cycle.
REQ-021 SHALL, when dstE == dstM != 4'hF, store valM (M port wins).
REQ-022 SHALL suppress the E-port write when icode == 4'h2 (cmovxx) and cnd == 0.
REQ-023 SHALL implement a two-state FSM RUN/HALTED; write enable active only in RUN and only when stat == AOK.
REQ-024 SHALL transition RUN->HALTED at the edge where stat != AOK; that instruction's writes SHALL be suppressed.
REQ-025 SHALL remain in HALTED until reset; halted = 1 in HALTED, 0 in RUN; reads remain functional in HALTED.
REQ-026 SHALL treat stat values outside 1..4 as non-AOK.

Reset
REQ-027 SHALL, on rst_n low, immediately clear registers 0..14 to 64'h0 except register 4 = RSP_RESET, enter RUN, and drive halted = 0.
REQ-028 SHALL discard any write coinciding with reset assertion; first write occurs at the first rising edge with rst_n high.

Structure
REQ-029 SHALL take RNONE (4'hF), register indices (RSP = 4), icode constants and stat encodings from the shared Y86 package also used by fetch, decode, execute and memory.
REQ-030 SHALL take the FSM state type from the shared package; no sub-modules; register array and write logic in this module.

Verification
REQ-031 SHALL cover: reset with RSP_RESET=64'h100 -> srcA=4 reads 64'h100, srcB=0 reads 0, halted=0.
REQ-032 SHALL cover: icode=3, dstE=2, valE=64'h1234, stat=1, one edge -> srcA=2 reads 64'h1234 after the edge, 0 before.
REQ-033 SHALL cover: popq %rsp, dstE=4 valE=64'h108, dstM=4 valM=64'hABCD -> register 4 = 64'hABCD.
REQ-034 SHALL cover: icode=2, cnd=0, dstE=3, valE=64'h55 -> register 3 unchanged; repeat with cnd=1 -> 64'h55.
REQ-035 SHALL cover: stat=2 with dstE=1 valE=64'h9 -> no write, halted=1; next cycle stat=1 dstE=1 -> still no write; rst_n pulse -> halted=0, register 1 = 0.
REQ-036 SHALL cover: rst_n asserted mid-cycle between edges with dstE=5 -> register 5 = 0 immediately, no write at the following edge while rst_n low.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared Y86-64 definitions used by fetch, decode, execute, memory and the
// writeback register file: register indices, instruction codes, status
// encodings and the writeback FSM state type.
// ----------------------------------------------------------------------------
package regfile_wb_pkg;

    // Register identifiers
    localparam logic [3:0] RNONE    = 4'hF;   // "no register" selector
    localparam logic [3:0] RRSP     = 4'h4;   // stack pointer %rsp
    localparam int         NUM_REGS = 15;     // architectural registers 0..14

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // also cmovxx
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Instruction status encodings
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Writeback FSM states
    typedef enum logic [0:0] {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

    // Only the exact AOK code counts as normal; every other value,
    // including unused encodings, stops the machine.
    function automatic logic stat_is_aok(input logic [2:0] s);
        return (s == STAT_AOK);
    endfunction

endpackage

// File: rtl/regfile_wb.sv
// ----------------------------------------------------------------------------
// regfile_wb
// Y86-64 register file with its writeback stage control.
//   - 15 x 64-bit registers (0..14); selector 4'hF means "none".
//   - Two combinational read ports (srcA/srcB -> valA/valB) that see the
//     contents held before the current rising edge.
//   - Two write ports (E: dstE/valE, M: dstM/valM) committed on the rising
//     edge; M wins when both target the same register.
//   - RUN/HALTED FSM: the first non-AOK status reaching writeback halts the
//     machine, suppresses that instruction's writes and all later ones.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   icode   in   4  instruction code in writeback
//   cnd     in   1  condition result (gates cmovxx E-port write)
//   stat    in   3  instruction status
//   dstE    in   4  E-port destination
//   dstM    in   4  M-port destination
//   valE    in  64  E-port data
//   valM    in  64  M-port data
//   srcA    in   4  read port A select
//   srcB    in   4  read port B select
//   valA    out 64  register[srcA] (0 for 4'hF)
//   valB    out 64  register[srcB] (0 for 4'hF)
//   halted  out  1  sticky halt indication
// ----------------------------------------------------------------------------
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter logic [63:0] RSP_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [2:0]  stat,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        halted
);

    logic [63:0] r_regs [0:NUM_REGS-1];
    wb_state_e   r_state;
    wb_state_e   w_state_next;
    logic        w_we;
    logic        w_we_e;
    logic        w_we_m;
    logic        w_cmov_fail;
    logic [63:0] w_val_a;
    logic [63:0] w_val_b;

    // Write-enable qualification for both ports
    always_comb begin
        w_we        = 1'b0;
        w_cmov_fail = 1'b0;
        w_we_e      = 1'b0;
        w_we_m      = 1'b0;
        w_we        = (r_state == WB_RUN) && stat_is_aok(stat);
        // A cmovxx whose condition failed behaves like a nop on the E port
        w_cmov_fail = (icode == I_RRMOVQ) && !cnd;
        w_we_e      = w_we && (dstE != RNONE) && !w_cmov_fail;
        w_we_m      = w_we && (dstM != RNONE);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WB_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: HALTED is absorbing until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WB_RUN: begin
                if (!stat_is_aok(stat)) begin
                    w_state_next = WB_HALTED;
                end else begin
                    w_state_next = WB_RUN;
                end
            end
            WB_HALTED: w_state_next = WB_HALTED;
            default:   w_state_next = WB_HALTED;
        endcase
    end

    // Register array: reset image, then edge-triggered writes with M priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (4'(i) == RRSP) ? RSP_RESET : 64'h0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we_m && (dstM == 4'(i))) begin
                    r_regs[i] <= valM;
                end else if (w_we_e && (dstE == 4'(i))) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

    // Combinational read ports; selector 4'hF has no storage and reads 0
    always_comb begin
        w_val_a = 64'h0;
        w_val_b = 64'h0;
        if (srcA != RNONE) begin
            w_val_a = r_regs[srcA];
        end else begin
            w_val_a = 64'h0;
        end
        if (srcB != RNONE) begin
            w_val_b = r_regs[srcB];
        end else begin
            w_val_b = 64'h0;
        end
    end

    assign valA   = w_val_a;
    assign valB   = w_val_b;
    assign halted = (r_state == WB_HALTED);

endmodule
